mux_8_1_arbiter: RTL and testbench
==================================

# mux_8_1_arbiter

Round-robin arbiter that shares one `mux_8_1` among eight single-bit requesters. Each requester raises `req[k]`. The arbiter grants one requester at a time and drives the mux select `s` to that requester's index. The shared mux output is presented as `y`, qualified by `busy`. The block sits between eight bit-serial sources and the single downstream consumer of the muxed line.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive grant cycles per requester. 0 means no limit. Legal range 0..255.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  8  request vector; bit k is requester k.
- `i`  in  8  data lines; bit k belongs to requester k and goes straight to the mux `i` input.
- `gnt`  out  8  one-hot grant, or all zero when idle.
- `s`  out  3  registered mux select; index of the current or last grantee.
- `busy`  out  1  high while a grant is active.
- `y`  out  1  `i[s]` when `busy`=1, else 0.

## Operation
- Registers:
  - `state` ∈ {IDLE, GRANT}
  - `ptr[2:0]`: highest-priority index
  - `s[2:0]`
  - `cnt[7:0]`: cycles in the current grant
- Reset (async, `rst_n`=0): `state`=IDLE, `gnt`=0, `busy`=0, `s`=0, `ptr`=0, `cnt`=0, so `y`=0. These values are held until the first rising `clk` after `rst_n` goes high.
- IDLE:
  - If `req`≠0, pick the first set bit scanning `ptr`, `ptr+1`, …, `ptr+7` (mod 8).
  - On that edge: `s`←winner, `gnt`←1<<winner, `busy`←1, `cnt`←0, `state`←GRANT.
  - If `req`=0, remain in IDLE with outputs unchanged; `s` keeps its last value.
- GRANT: release at this edge if `req[s]`=0, or if `MAX_HOLD`≠0 and `cnt`=`MAX_HOLD`−1.
  - On release: `gnt`←0, `busy`←0, `ptr`←`s`+1 (7 wraps to 0), `state`←IDLE.
  - Otherwise `cnt`←`cnt`+1, saturating at 255.
- At least one IDLE cycle always separates two grants. No back-to-back grants, including to different requesters.
- Requests from non-granted requesters are ignored during GRANT; they are evaluated in the next IDLE cycle.
- A requester that was preempted by timeout and still requests gets lowest priority on the next arbitration, because `ptr` moved past it.
- Single requester: regranted after the one-cycle IDLE gap.
- `y` is combinational: `busy & mux_y`, where `mux_y = i[s]`.

## Timing
- Request to grant: 1 edge. `req[k]` sampled high in IDLE gives `gnt[k]`=1 and `s`=k after that edge.
- Request drop to grant release: 1 edge. `req[s]` sampled low gives `gnt`=0 after that edge.
- Grant duration with a constant request: exactly `MAX_HOLD` cycles, followed by 1 IDLE cycle.
- `y` has zero-cycle latency from `i`; it follows `i[s]` combinationally while `busy`.
- `gnt`, `s` and `busy` change only on `clk` edges or on async reset.

## Structure
- Shared package holds:
  - `N_REQ`=8
  - `SEL_W`=3
  - the state encoding: IDLE=1'b0, GRANT=1'b1
- One sub-module: the existing `mux_8_1` (ports `i`, `s`, `y`), instanced as `u_mux`. The arbiter drives its `s`.
- The rotating priority encoder stays inline as a function. No separate module.

## Test plan
- Reset, then single request: `rst_n`=0 then 1; `req`=8'b0000_0100, `i`=8'b0000_0100 → one edge later `gnt`=8'b0000_0100, `s`=2, `busy`=1, `y`=1. Drop `req` → `gnt`=0 one edge later and `y`=0.
- Round-robin rotation: `req`=8'hFF held, `MAX_HOLD`=4 → grants in order 0,1,…,7,0. Each grant lasts 4 cycles, with 1 idle cycle between grants, 40-cycle period.
- Wrap-around priority: grant index 7, then release; `req`=8'b1000_0001 → next grant goes to 0, not 7.
- Unlimited hold: `MAX_HOLD`=0, `req`=8'b0001_0000 held 300 cycles with other bits set → `gnt` stays 8'b0001_0000 throughout and `cnt` saturates at 255.
- Reset mid-grant: during GRANT on index 5, pulse `rst_n` low between edges → `gnt`=0, `busy`=0, `s`=0, `y`=0 immediately, with no clock. After release, `req`=8'hFF → first grant goes to index 0.
- Mux path check: grant index 6 held; sweep `i` through 8'b0100_0000 and 8'b1011_1111 → `y` = 1 then 0, tracking `i[6]` with no clock delay.

Source files
------------

// File: rtl/mux_8_1_arbiter_pkg.sv
//------------------------------------------------------------------------------
// mux_8_1_arbiter_pkg
// Shared constants and state encoding for the round-robin mux arbiter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mux_8_1_arbiter_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mux_8_1_arbiter_if.sv
//------------------------------------------------------------------------------
// mux_8_1_arbiter_if
// Requester-side bundle: request/data lines in, grant/select/muxed data out.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mux_8_1_arbiter_if;
  import mux_8_1_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] i;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] s;
  logic             busy;
  logic             y;

  modport master (
    output req,
    output i,
    input  gnt,
    input  s,
    input  busy,
    input  y
  );

  modport slave (
    input  req,
    input  i,
    output gnt,
    output s,
    output busy,
    output y
  );

endinterface

`default_nettype wire

// File: rtl/mux_8_1_arbiter_mux.sv
//------------------------------------------------------------------------------
// mux_8_1
// Plain 8:1 single-bit multiplexer shared by the arbiter's requesters.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_8_1 (
  input  wire logic [7:0] i,
  input  wire logic [2:0] s,
  output      logic       y
);

  assign y = i[s];

endmodule

`default_nettype wire

// File: rtl/mux_8_1_arbiter.sv
//------------------------------------------------------------------------------
// mux_8_1_arbiter
// Round-robin arbiter granting one of eight requesters the shared mux_8_1.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mux_8_1_arbiter
  import mux_8_1_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input wire logic        clk,
  input wire logic        rst_n,
  mux_8_1_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_hold_last =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  generate
    if (MAX_HOLD > 255) begin : g_bad_hold
      $error("MAX_HOLD must be in 0..255");
    end
  endgenerate

  arb_state_e       r_state, w_state_nxt;
  logic [SEL_W-1:0] r_ptr,   w_ptr_nxt;
  logic [SEL_W-1:0] r_s,     w_s_nxt;
  logic [N_REQ-1:0] r_gnt,   w_gnt_nxt;
  logic             r_busy,  w_busy_nxt;
  logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;

  logic [SEL_W-1:0] w_winner;
  logic             w_hold_done;
  logic             w_mux_y;

  // First set request at or after ptr, wrapping modulo N_REQ.
  function automatic logic [SEL_W-1:0] rr_pick(
    input logic [N_REQ-1:0] req,
    input logic [SEL_W-1:0] ptr
  );
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign w_winner    = rr_pick(bus.req, r_ptr);
  assign w_hold_done = (MAX_HOLD != 0) && (r_cnt == c_hold_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_s     <= '0;
      r_gnt   <= '0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_s     <= w_s_nxt;
      r_gnt   <= w_gnt_nxt;
      r_busy  <= w_busy_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_s_nxt     = r_s;
    w_gnt_nxt   = r_gnt;
    w_busy_nxt  = r_busy;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_s_nxt     = w_winner;
          w_gnt_nxt   = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
          w_busy_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        // Release always passes through IDLE, so grants never run back-to-back.
        if (!bus.req[r_s] || w_hold_done) begin
          w_gnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_ptr_nxt   = r_s + 1'b1;
          w_state_nxt = IDLE;
        end else if (r_cnt != '1) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  mux_8_1 u_mux (
    .i (bus.i),
    .s (r_s),
    .y (w_mux_y)
  );

  assign bus.gnt  = r_gnt;
  assign bus.s    = r_s;
  assign bus.busy = r_busy;
  assign bus.y    = r_busy & w_mux_y;

endmodule

`default_nettype wire

// File: tb/tb_mux_8_1_arbiter.sv
//------------------------------------------------------------------------------
// tb_mux_8_1_arbiter
// Directed vector bench for the round-robin mux arbiter (limited and unlimited hold).
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mux_8_1_arbiter;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  mux_8_1_arbiter_if a ();
  mux_8_1_arbiter_if b ();

  mux_8_1_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  mux_8_1_arbiter #(.MAX_HOLD(0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic [7:0] i;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       busy;
    logic       y;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] g, input logic [2:0] s,
                       input logic bz, input logic y);
    chk({tag, ".gnt"},  32'(a.gnt),  32'(g));
    chk({tag, ".s"},    32'(a.s),    32'(s));
    chk({tag, ".busy"}, 32'(a.busy), 32'(bz));
    chk({tag, ".y"},    32'(a.y),    32'(y));
  endtask

  task automatic do_reset();
    @(negedge clk);
    a.req = '0;
    b.req = '0;
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_g;
    int p, g;
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    a.req = '0; a.i = '0;
    b.req = '0; b.i = '0;

    // Stepwise vectors from reset: single request, wrap to 0, timeout preemption.
    tbl[0]  = '{8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    tbl[1]  = '{8'h00, 8'h04, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[2]  = '{8'h00, 8'hFF, 8'h00, 3'd2, 1'b0, 1'b0};
    tbl[3]  = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    tbl[4]  = '{8'h81, 8'h00, 8'h80, 3'd7, 1'b1, 1'b0};
    tbl[5]  = '{8'h01, 8'h01, 8'h00, 3'd7, 1'b0, 1'b0};
    tbl[6]  = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    tbl[7]  = '{8'h81, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    tbl[8]  = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    tbl[9]  = '{8'h81, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    tbl[10] = '{8'h81, 8'h80, 8'h00, 3'd0, 1'b0, 1'b0};
    tbl[11] = '{8'h81, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    tbl[12] = '{8'h00, 8'h80, 8'h00, 3'd7, 1'b0, 1'b0};

    #1 rst_n = 1'b0;
    a.i = 8'hFF;
    #2;
    chk_a("reset", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 13; n++) begin
      a.req = tbl[n].req;
      a.i   = tbl[n].i;
      @(posedge clk);
      #1;
      chk_a($sformatf("vec%0d", n), tbl[n].gnt, tbl[n].s, tbl[n].busy, tbl[n].y);
    end

    // Full rotation with all requesting: 4 grant cycles then 1 idle per index.
    do_reset();
    a.req = 8'hFF;
    for (int n = 1; n <= 45; n++) begin
      @(posedge clk);
      #1;
      p = (n - 1) % 5;
      g = ((n - 1) / 5) % 8;
      exp_g = (p < 4) ? (8'h01 << g) : 8'h00;
      chk($sformatf("rot%0d.gnt", n), 32'(a.gnt), 32'(exp_g));
      chk($sformatf("rot%0d.s", n),   32'(a.s),   32'(g));
    end

    // Asynchronous reset in the middle of a grant to index 5.
    do_reset();
    a.req = 8'h20;
    @(posedge clk);
    #1;
    chk_a("mid.pre", 8'h20, 3'd5, 1'b1, 1'b0);
    @(negedge clk);
    a.i   = 8'hFF;
    rst_n = 1'b0;
    #1;
    chk_a("mid.rst", 8'h00, 3'd0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    a.req = 8'hFF;
    @(posedge clk);
    #1;
    chk_a("mid.post", 8'h01, 3'd0, 1'b1, 1'b1);

    // Combinational mux path while index 6 holds the grant.
    do_reset();
    a.req = 8'h40;
    a.i   = 8'h00;
    @(posedge clk);
    #1;
    chk_a("mux.g", 8'h40, 3'd6, 1'b1, 1'b0);
    a.i = 8'b0100_0000;
    #1;
    chk("mux.y1", 32'(a.y), 32'd1);
    a.i = 8'b1011_1111;
    #1;
    chk("mux.y0", 32'(a.y), 32'd0);

    // Unlimited hold: index 4 keeps the grant, count saturates.
    do_reset();
    a.req = '0;
    b.req = 8'h10;
    @(posedge clk);
    #1;
    b.req = 8'hFF;
    for (int n = 0; n < 300; n++) begin
      if (b.gnt !== 8'h10) begin
        chk($sformatf("hold%0d.gnt", n), 32'(b.gnt), 32'h10);
      end
      @(posedge clk);
      #1;
    end
    chk("hold.gnt",  32'(b.gnt),  32'h10);
    chk("hold.s",    32'(b.s),    32'd4);
    chk("hold.busy", 32'(b.busy), 32'd1);
    chk("hold.cnt",  32'(dut0.r_cnt), 32'd255);
    b.req = 8'h00;
    @(posedge clk);
    #1;
    chk("hold.rel", 32'(b.gnt), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
